// File: rtl/lc3_mem_pkg.sv
// Shared types and constants for the LC-3 style SRAM responder.
// Holds the FSM state encoding, the data word width and the default wait count.
package lc3_mem_pkg;

  localparam int WORD_W              = 16;
  localparam int DEFAULT_WAIT_CYCLES = 2;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_WAIT = 3'd1,
    RD_DATA = 3'd2,
    WR_WAIT = 3'd3,
    WR_DONE = 3'd4
  } state_e;

endpackage

// File: rtl/sram_responder_if.sv
// CPU-side SRAM bus: active-low strobes, word address and data in both directions.
// The master (CPU) drives strobes, address and write data; the slave returns status.
interface sram_responder_if;
  import lc3_mem_pkg::*;

  logic              Mem_CE;
  logic              Mem_UB;
  logic              Mem_LB;
  logic              Mem_OE;
  logic              Mem_WE;
  logic [15:0]       ADDR;
  logic [WORD_W-1:0] Data_in;
  logic [WORD_W-1:0] Data_out;
  logic              Data_valid;
  logic              Busy;
  logic              Oob_err;

  modport master (
    output Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE, ADDR, Data_in,
    input  Data_out, Data_valid, Busy, Oob_err
  );

  modport slave (
    input  Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE, ADDR, Data_in,
    output Data_out, Data_valid, Busy, Oob_err
  );
endinterface

// File: rtl/sram_array.sv
// Word storage with byte-lane write enables and a registered read port.
// Contents are never reset; the read register only updates when re is high.
module sram_array
  import lc3_mem_pkg::*;
#(
  parameter int DEPTH_LOG2 = 8
) (
  input  logic                  Clk,
  input  logic                  we,
  input  logic [1:0]            be,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [WORD_W-1:0]     wdata,
  input  logic                  re,
  output logic [WORD_W-1:0]     rd_data_q
);

  logic [WORD_W-1:0] mem [0:(1<<DEPTH_LOG2)-1];

  always_ff @(posedge Clk) begin
    if (we) begin
      if (be[0]) mem[addr][7:0]  <= wdata[7:0];
      if (be[1]) mem[addr][15:8] <= wdata[15:8];
    end
    if (re) rd_data_q <= mem[addr];
  end

endmodule

// File: rtl/sram_responder.sv
// Asynchronous-style SRAM bus responder: turns CE/OE/WE strobe windows into
// single reads/writes of sram_array with fixed wait states and range checking.
module sram_responder
  import lc3_mem_pkg::*;
#(
  parameter int DEPTH_LOG2  = 8,
  parameter int WAIT_CYCLES = DEFAULT_WAIT_CYCLES
) (
  input  logic           Clk,
  input  logic           Reset,
  sram_responder_if.slave bus
);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] addr_q, addr_d;
  logic        ub_q, ub_d, lb_q, lb_d;
  logic [1:0]  lane_q, lane_d;
  logic        valid_q, valid_d;
  logic        oob_q, oob_d;
  logic        busy_q, busy_d;

  logic              rd_strobe, wr_strobe;
  logic [15:0]       acc_addr;
  logic              acc_ub, acc_lb, acc_oob;
  logic              load, we_arr;
  logic [WORD_W-1:0] rd_data;

  // In IDLE the window-start edge may also be the access edge, so use live bus values.
  always_comb begin
    rd_strobe = !bus.Mem_CE && !bus.Mem_OE;
    wr_strobe = !bus.Mem_CE && !bus.Mem_WE;
    acc_addr  = (state_q == IDLE) ? bus.ADDR    : addr_q;
    acc_ub    = (state_q == IDLE) ? !bus.Mem_UB : ub_q;
    acc_lb    = (state_q == IDLE) ? !bus.Mem_LB : lb_q;
    acc_oob   = (acc_addr >> DEPTH_LOG2) != 16'h0000;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    ub_d    = ub_q;
    lb_d    = lb_q;
    lane_d  = lane_q;
    valid_d = valid_q;
    oob_d   = 1'b0;
    load    = 1'b0;
    we_arr  = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = 4'd0;
        if (wr_strobe || rd_strobe) begin
          cnt_d  = 4'd1;
          addr_d = bus.ADDR;
          ub_d   = !bus.Mem_UB;
          lb_d   = !bus.Mem_LB;
          if (wr_strobe)             state_d = WR_WAIT;
          else if (WAIT_CYCLES <= 2) load    = 1'b1;
          else                       state_d = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (!rd_strobe) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end else if (cnt_q == 4'(WAIT_CYCLES - 2)) begin
          load = 1'b1;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      RD_DATA: begin
        if (!rd_strobe) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
          valid_d = 1'b0;
        end
      end
      WR_WAIT: begin
        if (!wr_strobe) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end else if (cnt_q == 4'(WAIT_CYCLES - 1)) begin
          we_arr  = !acc_oob;
          oob_d   = acc_oob;
          state_d = WR_DONE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      WR_DONE: begin
        if (!wr_strobe) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase

    // Out-of-range reads zero both lanes instead of returning aliased storage.
    if (load) begin
      state_d = RD_DATA;
      valid_d = 1'b1;
      oob_d   = acc_oob;
      lane_d  = acc_oob ? 2'b00 : {acc_ub, acc_lb};
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      lane_q  <= 2'b00;
      valid_q <= 1'b0;
      oob_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lane_q  <= lane_d;
      valid_q <= valid_d;
      oob_q   <= oob_d;
      busy_q  <= busy_d;
    end
    addr_q <= addr_d;
    ub_q   <= ub_d;
    lb_q   <= lb_d;
  end

  // Reset on the commit edge must still suppress the write.
  sram_array #(.DEPTH_LOG2(DEPTH_LOG2)) u_array (
    .Clk       (Clk),
    .we        (we_arr && !Reset),
    .be        ({ub_q, lb_q}),
    .addr      (acc_addr[DEPTH_LOG2-1:0]),
    .wdata     (bus.Data_in),
    .re        (load),
    .rd_data_q (rd_data)
  );

  assign bus.Data_out   = {lane_q[1] ? rd_data[15:8] : 8'h00,
                           lane_q[0] ? rd_data[7:0]  : 8'h00};
  assign bus.Data_valid = valid_q;
  assign bus.Busy       = busy_q;
  assign bus.Oob_err    = oob_q;

endmodule

// File: tb/tb_sram_responder.sv
// Directed bench for sram_responder (DEPTH_LOG2=8, WAIT_CYCLES=2) with a read scoreboard.
module tb_sram_responder;
  logic Clk = 1'b0;
  logic Reset;
  int   checks = 0;
  int   failures = 0;
  logic [15:0] exp_q [$];
  int   oobs;

  sram_responder_if bus ();

  sram_responder #(.DEPTH_LOG2(8), .WAIT_CYCLES(2)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus.slave)
  );

  always #5 Clk = ~Clk;

  task automatic cycle();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic bus_idle();
    bus.Mem_CE = 1'b1; bus.Mem_OE = 1'b1; bus.Mem_WE = 1'b1;
    bus.Mem_UB = 1'b0; bus.Mem_LB = 1'b0;
  endtask

  // Two WE-low cycles, then one idle cycle; returns the number of Oob_err pulses seen.
  task automatic wr(input logic [15:0] a, input logic [15:0] d,
                    input logic ub_n, input logic lb_n, output int n_oob);
    n_oob = 0;
    bus.ADDR = a; bus.Data_in = d; bus.Mem_UB = ub_n; bus.Mem_LB = lb_n;
    bus.Mem_CE = 1'b0; bus.Mem_WE = 1'b0;
    cycle(); n_oob += int'(bus.Oob_err);
    cycle(); n_oob += int'(bus.Oob_err);
    bus_idle();
    cycle(); n_oob += int'(bus.Oob_err);
  endtask

  // Two OE-low cycles, then one idle cycle; data checked against the scoreboard.
  task automatic rd(input string tag, input logic [15:0] a, input logic [15:0] exp,
                    input logic ub_n, input logic lb_n, output int n_oob);
    logic [15:0] e;
    n_oob = 0;
    exp_q.push_back(exp);
    bus.ADDR = a; bus.Mem_UB = ub_n; bus.Mem_LB = lb_n;
    bus.Mem_CE = 1'b0; bus.Mem_OE = 1'b0;
    cycle(); n_oob += int'(bus.Oob_err);
    chk({tag, "_valid"}, 16'(bus.Data_valid), 16'h1);
    if (bus.Data_valid && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({tag, "_data"}, bus.Data_out, e);
    end
    cycle(); n_oob += int'(bus.Oob_err);
    bus_idle();
    cycle(); n_oob += int'(bus.Oob_err);
    chk({tag, "_valid_off"}, 16'(bus.Data_valid), 16'h0);
    chk({tag, "_retain"}, bus.Data_out, exp);
  endtask

  initial begin
    Reset = 1'b1;
    bus_idle();
    bus.ADDR = 16'h0000; bus.Data_in = 16'h0000;
    cycle(); cycle();
    chk("rst_data_out", bus.Data_out, 16'h0000);
    chk("rst_valid", 16'(bus.Data_valid), 16'h0);
    chk("rst_busy", 16'(bus.Busy), 16'h0);
    chk("rst_oob", 16'(bus.Oob_err), 16'h0);
    Reset = 1'b0;
    cycle();

    // Write then read
    wr(16'h0012, 16'hBEEF, 1'b0, 1'b0, oobs);
    chk("wr_beef_oob", 16'(oobs), 16'h0);
    rd("rd_beef", 16'h0012, 16'hBEEF, 1'b0, 1'b0, oobs);

    // Busy during a write window
    bus.ADDR = 16'h0013; bus.Data_in = 16'h0F0F;
    bus.Mem_CE = 1'b0; bus.Mem_WE = 1'b0;
    cycle();
    chk("busy_wr_wait", 16'(bus.Busy), 16'h1);
    cycle(); bus_idle(); cycle();
    chk("busy_after_wr", 16'(bus.Busy), 16'h0);

    // Byte lanes
    wr(16'h0020, 16'h1234, 1'b0, 1'b0, oobs);
    wr(16'h0020, 16'hAB00, 1'b0, 1'b1, oobs);
    rd("rd_lanes", 16'h0020, 16'hAB34, 1'b0, 1'b0, oobs);
    rd("rd_lb_only", 16'h0020, 16'h0034, 1'b1, 1'b0, oobs);
    rd("rd_ub_only", 16'h0020, 16'hAB00, 1'b0, 1'b1, oobs);

    // Both lanes disabled: handshake completes, storage unchanged
    wr(16'h0060, 16'h6060, 1'b0, 1'b0, oobs);
    wr(16'h0060, 16'h2222, 1'b1, 1'b1, oobs);
    rd("rd_no_lanes", 16'h0060, 16'h6060, 1'b0, 1'b0, oobs);

    // Write abort after one cycle
    wr(16'h0030, 16'h5555, 1'b0, 1'b0, oobs);
    bus.ADDR = 16'h0030; bus.Data_in = 16'hFFFF;
    bus.Mem_CE = 1'b0; bus.Mem_WE = 1'b0;
    cycle();
    bus_idle();
    cycle();
    chk("abort_busy", 16'(bus.Busy), 16'h0);
    rd("rd_abort", 16'h0030, 16'h5555, 1'b0, 1'b0, oobs);

    // Out of range
    wr(16'h0000, 16'h1111, 1'b0, 1'b0, oobs);
    wr(16'h0100, 16'h9999, 1'b0, 1'b0, oobs);
    chk("oob_wr_pulses", 16'(oobs), 16'h1);
    rd("rd_addr0", 16'h0000, 16'h1111, 1'b0, 1'b0, oobs);
    chk("inrange_rd_oob", 16'(oobs), 16'h0);
    rd("rd_oob", 16'h0100, 16'h0000, 1'b0, 1'b0, oobs);
    chk("oob_rd_pulses", 16'(oobs), 16'h1);

    // Reset during WR_WAIT
    wr(16'h0040, 16'h7777, 1'b0, 1'b0, oobs);
    rd("rd_pre_rst", 16'h0012, 16'hBEEF, 1'b0, 1'b0, oobs);
    bus.ADDR = 16'h0040; bus.Data_in = 16'h0BAD;
    bus.Mem_CE = 1'b0; bus.Mem_WE = 1'b0;
    cycle();
    Reset = 1'b1;
    cycle();
    chk("midrst_data_out", bus.Data_out, 16'h0000);
    chk("midrst_valid", 16'(bus.Data_valid), 16'h0);
    chk("midrst_busy", 16'(bus.Busy), 16'h0);
    Reset = 1'b0;
    bus_idle();
    cycle();
    rd("rd_after_rst", 16'h0040, 16'h7777, 1'b0, 1'b0, oobs);

    // CPU fetch loop, back-to-back windows
    wr(16'h0050, 16'h3001, 1'b0, 1'b0, oobs);
    wr(16'h0051, 16'h5262, 1'b0, 1'b0, oobs);
    wr(16'h0052, 16'h0FFE, 1'b0, 1'b0, oobs);
    rd("fetch0", 16'h0050, 16'h3001, 1'b0, 1'b0, oobs);
    rd("fetch1", 16'h0051, 16'h5262, 1'b0, 1'b0, oobs);
    rd("fetch2", 16'h0052, 16'h0FFE, 1'b0, 1'b0, oobs);

    chk("scoreboard_empty", 16'(exp_q.size()), 16'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sram_responder.md
SRAM_RESPONDER -- requirements
Module: sram_responder

Interface
REQ-001 Parameter: DEPTH_LOG2, default 8, log2 of word count of storage.
REQ-002 Parameter: WAIT_CYCLES, default 2, strobe-low cycles per access; legal range 2..8.
REQ-003 Clk  input  1  clock; all state changes on rising edge.
REQ-004 Reset  input  1  reset Reset, synchronous, active-high; clock Clk.
REQ-005 Mem_CE  input  1  chip enable, active-low.
REQ-006 Mem_UB  input  1  upper-byte lane [15:8] enable, active-low.
REQ-007 Mem_LB  input  1  lower-byte lane [7:0] enable, active-low.
REQ-008 Mem_OE  input  1  output (read) enable, active-low.
REQ-009 Mem_WE  input  1  write enable, active-low.
REQ-010 ADDR  input  16  word address, driven from the CPU's MAR.
REQ-011 Data_in  input  16  write data, driven from the CPU's MDR.
REQ-012 Data_out  output  16  registered read data.
REQ-013 Data_valid  output  1  Data_out holds the data for the current read window.
REQ-014 Busy  output  1  high whenever the FSM is not in IDLE.
REQ-015 Oob_err  output  1  one-cycle pulse on out-of-range access.

Function
REQ-016 FSM states: IDLE, RD_WAIT, RD_DATA, WR_WAIT, WR_DONE.
REQ-017 Access window: consecutive cycles with Mem_CE low and the strobe (Mem_OE or Mem_WE) low, sampled at rising edges.
REQ-018 IDLE: CE low and WE low -> write window starts (WE has priority over OE); otherwise CE low and OE low -> read window starts; otherwise remain in IDLE.
REQ-019 Window start: capture ADDR, Mem_UB and Mem_LB, and set the cycle counter to 1; later ADDR changes in the window are ignored.
REQ-020 Read: at the edge ending the (WAIT_CYCLES-1)-th window cycle, load Data_out from the array and enter RD_DATA; RD_WAIT is used only when WAIT_CYCLES>2.
REQ-021 Read timing: with WAIT_CYCLES=2, Data_valid is high during the 2nd OE-low cycle, so the CPU's MDR load at the end of that cycle captures the data.
REQ-022 RD_DATA: Data_valid=1 while CE and OE stay low; OE or CE high -> IDLE, with Data_valid=0 from the next cycle.
REQ-023 Read lanes: disabled lanes return 8'h00 in their byte of Data_out.
REQ-024 Write: at the edge ending the WAIT_CYCLES-th window cycle, sample Data_in and write the enabled lanes at the captured address, then enter WR_DONE.
REQ-025 WR_DONE: no further write is made; WE or CE high -> IDLE; exactly one commit per window.
REQ-026 Abort: strobe or CE high before read-data load or write commit -> IDLE, with no commit and Data_valid never asserted.
REQ-027 Retention: Data_out holds its last value outside read windows.
REQ-028 Out of range: ADDR[15:DEPTH_LOG2] nonzero -> write suppressed, read returns 16'h0000, and Oob_err pulses for 1 cycle at the commit or load edge.
REQ-029 Both lanes disabled: the write completes its handshake but changes no storage.
REQ-030 Back-to-back windows: a new window may start on the cycle after the return to IDLE.

Reset
REQ-031 Reset forces state=IDLE, counter=0, Data_out=16'h0000, Data_valid=0, Oob_err=0 and Busy=0.
REQ-032 Storage contents are not cleared by Reset.
REQ-033 Reset during WR_WAIT suppresses the pending write.

Structure
REQ-034 Package lc3_mem_pkg holds the FSM state enum, WORD_W=16 and the default WAIT_CYCLES.
REQ-035 Sub-module sram_array holds the storage: synchronous read, byte-enable synchronous write, depth 2**DEPTH_LOG2.
REQ-036 The FSM, counter, capture registers and Oob_err logic sit in sram_responder.

Verification
REQ-037 Write then read: write 16'hBEEF to 0x0012 with WE low for 2 cycles, then OE low for 2 cycles -> Data_valid high in the 2nd cycle and Data_out=16'hBEEF.
REQ-038 Byte lanes: location holds 16'h1234; write 16'hAB00 with only UB low; read with both lanes low -> 16'hAB34.
REQ-039 Write abort: WE low for 1 cycle, then high -> location unchanged and FSM back in IDLE.
REQ-040 Out of range: write to 0x0100 with DEPTH_LOG2=8 -> Oob_err pulses once and address 0x0000 is unchanged; read of 0x0100 -> Data_out=16'h0000.
REQ-041 Reset mid-write: Reset asserted during WR_WAIT -> no write, and Data_out, Data_valid and Busy all 0 next cycle.
REQ-042 CPU loop: fetch sequence with OE low for 2 cycles, then idle, repeated 3 times back-to-back -> each read returns the preloaded word with one Data_valid cycle per window.
